quiz_round_checker: RTL and testbench

- Challenge side of the binary-equivalent calculator game: generates operand pairs and an operation, waits for the player's switch answer, grades it against the true product/quotient, and keeps score over a fixed number of rounds.
- Feeds the operand/score display path; consumes the debounced submit/start button pulses and the answer switches.

---
 rtl/quiz_round_checker.sv | 185 ++++++++++++++++++
 tb/tb_quiz_round_checker.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quiz_round_checker.sv
// Challenge side of the binary calculator game: generates operands,
// grades the player's answer and keeps score over a fixed number of rounds.
module quiz_round_checker #(
   parameter int          ROUNDS          = 8,
   parameter int          TIMEOUT_CYCLES  = 50000000,
   parameter int          FEEDBACK_CYCLES = 25000000,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       submit,
   input  logic [7:0] answer,
   output logic [4:0] op_a,
   output logic [3:0] op_b,
   output logic       op_sel,
   output logic [3:0] round,
   output logic [3:0] score,
   output logic       busy,
   output logic       done,
   output logic       result_valid,
   output logic       result_ok,
   output logic       timed_out
);

   // One timer serves both the answer window and the feedback hold.
   localparam int TMAX = (TIMEOUT_CYCLES > FEEDBACK_CYCLES) ?
                         TIMEOUT_CYCLES : FEEDBACK_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] FB_LAST    = TW'(FEEDBACK_CYCLES - 1);
   localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
   localparam logic [3:0]    LAST_ROUND = 4'(ROUNDS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GEN,
      S_WAIT,
      S_SHOW,
      S_DONE
   } state_t;

   state_t        r_state;
   logic [15:0]   r_lfsr;
   logic [TW-1:0] r_timer;
   logic [4:0]    r_op_a;
   logic [3:0]    r_op_b;
   logic          r_op_sel;
   logic [3:0]    r_round;
   logic [3:0]    r_score;
   logic          r_busy;
   logic          r_done;
   logic          r_result_valid;
   logic          r_result_ok;
   logic          r_timed_out;

   logic          w_lfsr_fb;
   logic [4:0]    w_gen_a;
   logic [3:0]    w_gen_b;
   logic          w_gen_sel;
   logic [7:0]    w_prod;
   logic [4:0]    w_div;
   logic [4:0]    w_quot;
   logic [7:0]    w_expected;
   logic          w_match;

   // Taps for x^16 + x^14 + x^13 + x^11 + 1, shifting toward the MSB.
   assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

   // Free-running LFSR so operands depend on when the player acts.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lfsr <= LFSR_SEED;
      end else begin
         r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
      end
   end

   // Next challenge drawn from the LFSR; multiply keeps op_a below 16.
   always_comb begin
      w_gen_sel = r_lfsr[9];
      w_gen_b   = (r_lfsr[8:5] == 4'd0) ? 4'd1 : r_lfsr[8:5];
      w_gen_a   = {r_lfsr[4] & r_lfsr[9], r_lfsr[3:0]};
   end

   // True result of the current challenge and the grade of the answer.
   always_comb begin
      w_prod     = {4'd0, r_op_a[3:0]} * {4'd0, r_op_b};
      w_div      = (r_op_b == 4'd0) ? 5'd1 : {1'b0, r_op_b};
      w_quot     = r_op_a / w_div;
      w_expected = r_op_sel ? {3'd0, w_quot} : w_prod;
      w_match    = (answer == w_expected);
   end

   // Game sequencer with all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_timer        <= '0;
         r_op_a         <= '0;
         r_op_b         <= '0;
         r_op_sel       <= 1'b0;
         r_round        <= '0;
         r_score        <= '0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_result_valid <= 1'b0;
         r_result_ok    <= 1'b0;
         r_timed_out    <= 1'b0;
      end else begin
         r_result_valid <= 1'b0;
         unique case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_state <= S_GEN;
                  r_score <= 4'd0;
                  r_round <= 4'd1;
                  r_done  <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            S_GEN: begin
               r_op_a      <= w_gen_a;
               r_op_b      <= w_gen_b;
               r_op_sel    <= w_gen_sel;
               r_result_ok <= 1'b0;
               r_timed_out <= 1'b0;
               r_timer     <= '0;
               r_state     <= S_WAIT;
            end
            S_WAIT: begin
               // A submit on the last allowed cycle still counts.
               if (submit) begin
                  r_result_ok    <= w_match;
                  r_timed_out    <= 1'b0;
                  r_score        <= r_score + {3'd0, w_match};
                  r_result_valid <= 1'b1;
                  r_timer        <= '0;
                  r_state        <= S_SHOW;
               end else if (r_timer == TO_LAST) begin
                  r_result_ok    <= 1'b0;
                  r_timed_out    <= 1'b1;
                  r_result_valid <= 1'b1;
                  r_timer        <= '0;
                  r_state        <= S_SHOW;
               end else begin
                  r_timer <= r_timer + TIMER_ONE;
               end
            end
            S_SHOW: begin
               if (r_timer == FB_LAST) begin
                  r_timer <= '0;
                  if (r_round == LAST_ROUND) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_round <= 4'd0;
                  end else begin
                     r_round <= r_round + 4'd1;
                     r_state <= S_GEN;
                  end
               end else begin
                  r_timer <= r_timer + TIMER_ONE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign op_a         = r_op_a;
   assign op_b         = r_op_b;
   assign op_sel       = r_op_sel;
   assign round        = r_round;
   assign score        = r_score;
   assign busy         = r_busy;
   assign done         = r_done;
   assign result_valid = r_result_valid;
   assign result_ok    = r_result_ok;
   assign timed_out    = r_timed_out;

endmodule

// File: tb/tb_quiz_round_checker.sv
// Bench for quiz_round_checker: cycle model of the game rules,
// a table of graded rounds, hand sequences and a random soak.
module tb_quiz_round_checker;

   localparam int          R    = 3;
   localparam int          TO   = 20;
   localparam int          FB   = 4;
   localparam logic [15:0] SEED = 16'hACE1;
   localparam int          TAPS [4] = '{16, 14, 13, 11};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       submit = 1'b0;
   logic [7:0] answer = 8'd0;
   logic [4:0] op_a;
   logic [3:0] op_b;
   logic       op_sel;
   logic [3:0] round;
   logic [3:0] score;
   logic       busy;
   logic       done;
   logic       result_valid;
   logic       result_ok;
   logic       timed_out;

   always #5 clk = ~clk;

   quiz_round_checker #(
      .ROUNDS         (R),
      .TIMEOUT_CYCLES (TO),
      .FEEDBACK_CYCLES(FB),
      .LFSR_SEED      (SEED)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .submit      (submit),
      .answer      (answer),
      .op_a        (op_a),
      .op_b        (op_b),
      .op_sel      (op_sel),
      .round       (round),
      .score       (score),
      .busy        (busy),
      .done        (done),
      .result_valid(result_valid),
      .result_ok   (result_ok),
      .timed_out   (timed_out)
   );

   int errors = 0;
   int checks = 0;
   int shown  = 0;

   typedef enum int {P_IDLE, P_GEN, P_WAIT, P_SHOW, P_DONE} phase_t;

   phase_t      ph = P_IDLE;
   logic [15:0] m_lfsr = SEED;
   int m_a = 0, m_b = 0, m_sel = 0, m_round = 0, m_score = 0;
   int m_busy = 0, m_done = 0, m_rv = 0, m_ok = 0, m_to = 0;
   int cyc = 0, wait_start = 0, show_left = 0;

   function automatic logic [15:0] lfsr_step(input logic [15:0] q);
      logic fb;
      fb = 1'b0;
      foreach (TAPS[k]) fb = fb ^ q[TAPS[k] - 1];
      return {q[14:0], fb};
   endfunction

   function automatic int ref_result(input int a, input int b, input int sel);
      if (b == 0) return 0;
      return (sel != 0) ? (a / b) : (a * b);
   endfunction

   // Reference model of the game, stepped on every rising clock edge.
   always @(posedge clk) begin
      logic [15:0] l;
      cyc++;
      if (rst) begin
         ph = P_IDLE;  m_lfsr = SEED;
         m_a = 0; m_b = 0; m_sel = 0; m_round = 0; m_score = 0;
         m_busy = 0; m_done = 0; m_rv = 0; m_ok = 0; m_to = 0;
      end else begin
         l = m_lfsr;
         m_lfsr = lfsr_step(m_lfsr);
         m_rv = 0;
         case (ph)
            P_IDLE, P_DONE: begin
               if (start) begin
                  ph = P_GEN; m_score = 0; m_round = 1;
                  m_done = 0; m_busy = 1;
               end
            end
            P_GEN: begin
               m_sel = int'(l[9]);
               m_b   = (l[8:5] == 4'd0) ? 1 : int'(l[8:5]);
               m_a   = (m_sel != 0) ? int'(l[4:0]) : int'(l[3:0]);
               m_ok = 0; m_to = 0;
               wait_start = cyc;
               ph = P_WAIT;
            end
            P_WAIT: begin
               if (submit) begin
                  m_ok = (int'(answer) == ref_result(m_a, m_b, m_sel)) ? 1 : 0;
                  m_to = 0; m_score += m_ok; m_rv = 1;
                  show_left = FB; ph = P_SHOW;
               end else if (cyc - wait_start == TO) begin
                  m_ok = 0; m_to = 1; m_rv = 1;
                  show_left = FB; ph = P_SHOW;
               end
            end
            P_SHOW: begin
               show_left--;
               if (show_left == 0) begin
                  if (m_round == R) begin
                     ph = P_DONE; m_busy = 0; m_done = 1; m_round = 0;
                  end else begin
                     m_round++; ph = P_GEN;
                  end
               end
            end
            default: ph = P_IDLE;
         endcase
      end
   end

   task automatic tick();
      logic [22:0] g, w;
      @(posedge clk);
      #1;
      g = {op_a, op_b, op_sel, round, score, busy, done,
           result_valid, result_ok, timed_out};
      w = {5'(m_a), 4'(m_b), 1'(m_sel), 4'(m_round), 4'(m_score),
           1'(m_busy), 1'(m_done), 1'(m_rv), 1'(m_ok), 1'(m_to)};
      checks++;
      if (g !== w) begin
         errors++;
         if (shown < 20) begin
            shown++;
            $display("FAIL model_cycle t=%0t got=%h want=%h", $time, g, w);
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic wait_ph(input phase_t p);
      int n;
      n = 0;
      while (ph != p && n < 200) begin
         tick();
         n++;
      end
      chk("reach_phase", (ph == p) ? 1 : 0, 1);
   endtask

   typedef struct {
      int dly;
      int mode;
      int want_ok;
      int want_to;
      int want_score;
   } vec_t;

   localparam int M_RIGHT = 0;
   localparam int M_WRONG = 1;
   localparam int M_NONE  = 2;

   task automatic apply(input vec_t v);
      int exp_v;
      wait_ph(P_WAIT);
      if (v.mode == M_NONE) begin
         repeat (TO) tick();
      end else begin
         repeat (v.dly - 1) tick();
         exp_v = ref_result(m_a, m_b, m_sel);
         answer = (v.mode == M_RIGHT) ? 8'(exp_v) : (8'(exp_v) ^ 8'h01);
         submit = 1'b1;
         tick();
         submit = 1'b0;
      end
      chk("rv_pulse", result_valid, 1);
      chk("result_ok", result_ok, v.want_ok);
      chk("timed_out", timed_out, v.want_to);
      chk("score", score, v.want_score);
      tick();
      chk("rv_single", result_valid, 0);
   endtask

   task automatic endgame(input int want_score);
      wait_ph(P_DONE);
      chk("done_end", {done, busy, round}, {1'b1, 1'b0, 4'd0});
      chk("score_held", score, want_score);
      for (int i = 0; i < 3; i++) begin
         submit = 1'b1;
         tick();
         submit = 1'b0;
         tick();
         chk("no_rv_done", result_valid, 0);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("restart", {score, round, done, busy},
          {4'd0, 4'd1, 1'b0, 1'b1});
   endtask

   task automatic check_first_gen();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_busy", {busy, round}, {1'b1, 4'd1});
      tick();
      chk("op_b_nonzero", (op_b != 4'd0) ? 1 : 0, 1);
      chk("op_a_range", (op_sel == 1'b0 && op_a >= 5'd16) ? 1 : 0, 0);
   endtask

   vec_t tbl [6];

   initial begin
      tbl[0] = '{dly: 5,  mode: M_RIGHT, want_ok: 1, want_to: 0, want_score: 1};
      tbl[1] = '{dly: 5,  mode: M_WRONG, want_ok: 0, want_to: 0, want_score: 1};
      tbl[2] = '{dly: 0,  mode: M_NONE,  want_ok: 0, want_to: 1, want_score: 1};
      tbl[3] = '{dly: 20, mode: M_RIGHT, want_ok: 1, want_to: 0, want_score: 1};
      tbl[4] = '{dly: 1,  mode: M_WRONG, want_ok: 0, want_to: 0, want_score: 1};
      tbl[5] = '{dly: 3,  mode: M_RIGHT, want_ok: 1, want_to: 0, want_score: 2};

      rst = 1'b1;
      tick();
      tick();
      chk("reset_outputs",
          {op_a, op_b, op_sel, round, score, busy, done,
           result_valid, result_ok, timed_out}, 0);
      rst = 1'b0;
      repeat (3) tick();

      check_first_gen();
      for (int i = 0; i < 6; i++) begin
         if (i == 3) endgame(1);
         apply(tbl[i]);
      end
      endgame(2);

      apply(tbl[0]);
      wait_ph(P_WAIT);
      chk("round2", round, 2);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_reset",
          {op_a, op_b, op_sel, round, score, busy, done,
           result_valid, result_ok, timed_out}, 0);
      tick();
      check_first_gen();

      for (int k = 0; k < 2500; k++) begin
         start  = ($urandom_range(0, 39) == 0);
         submit = ($urandom_range(0, 5) == 0);
         rst    = ($urandom_range(0, 599) == 0);
         answer = ($urandom_range(0, 1) == 1) ?
                  8'(ref_result(m_a, m_b, m_sel)) : 8'($urandom);
         tick();
      end
      start  = 1'b0;
      submit = 1'b0;
      rst    = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
